// File: rtl/bsg_dmc_ui_arbiter.sv
// Two-requester arbiter in front of a single DMC UI port.
// Commands are granted round-robin and held until the controller accepts them.
// Write bursts are forwarded beat by beat from the winning requester.
// A small FIFO remembers which requester issued each read so returned data can be routed back.
module bsg_dmc_ui_arbiter #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32,
    parameter int burst_len_p  = 2,
    parameter int rd_ids_els_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [2*addr_width_p-1:0]       req_app_addr_i,
    input  logic [2*3-1:0]                  req_app_cmd_i,
    input  logic [1:0]                      req_app_en_i,
    output logic [1:0]                      req_app_rdy_o,
    input  logic [1:0]                      req_app_wdf_wren_i,
    input  logic [2*data_width_p-1:0]       req_app_wdf_data_i,
    input  logic [2*(data_width_p/8)-1:0]   req_app_wdf_mask_i,
    input  logic [1:0]                      req_app_wdf_end_i,
    output logic [1:0]                      req_app_wdf_rdy_o,
    output logic [1:0]                      req_app_rd_data_valid_o,
    output logic [data_width_p-1:0]         req_app_rd_data_o,
    output logic [1:0]                      req_app_rd_data_end_o,

    output logic [addr_width_p-1:0]         app_addr_o,
    output logic [2:0]                      app_cmd_o,
    output logic                            app_en_o,
    input  logic                            app_rdy_i,
    output logic                            app_wdf_wren_o,
    output logic [data_width_p-1:0]         app_wdf_data_o,
    output logic [(data_width_p/8)-1:0]     app_wdf_mask_o,
    output logic                            app_wdf_end_o,
    input  logic                            app_wdf_rdy_i,
    input  logic                            app_rd_data_valid_i,
    input  logic [data_width_p-1:0]         app_rd_data_i,
    input  logic                            app_rd_data_end_i,

    output logic                            busy_o
);

    localparam int mask_width_lp = data_width_p / 8;
    localparam int cnt_width_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int ptr_width_lp  = (rd_ids_els_p > 1) ? $clog2(rd_ids_els_p) : 1;
    localparam int fill_width_lp = $clog2(rd_ids_els_p + 1);

    typedef enum logic [2:0] {
        APP_CMD_WRITE = 3'd0,
        APP_CMD_READ  = 3'd1
    } app_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WDATA
    } state_e;

    state_e                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      last_grant_q, last_grant_d;
    logic [cnt_width_lp-1:0]   beat_cnt_q, beat_cnt_d;

    logic [rd_ids_els_p-1:0]   fifo_mem_q, fifo_mem_d;
    logic [ptr_width_lp-1:0]   fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [ptr_width_lp-1:0]   fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [fill_width_lp-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic                      fifo_full, fifo_empty, fifo_head;
    logic                      fifo_push, fifo_pop;

    logic [addr_width_p-1:0]   sel_addr;
    logic [2:0]                sel_cmd;
    logic                      sel_en, sel_wren, sel_wdf_end;
    logic [data_width_p-1:0]   sel_wdf_data;
    logic [mask_width_lp-1:0]  sel_wdf_mask;

    logic [1:0]                req_is_read, eligible;
    logic                      pick;
    logic                      cmd_accept, wdf_beat, last_beat;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(rd_ids_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Slice out the granted requester's command and write-data fields.
    always_comb begin
        sel_addr     = grant_q ? req_app_addr_i[addr_width_p +: addr_width_p]
                               : req_app_addr_i[0 +: addr_width_p];
        sel_cmd      = grant_q ? req_app_cmd_i[5:3] : req_app_cmd_i[2:0];
        sel_en       = req_app_en_i[grant_q];
        sel_wren     = req_app_wdf_wren_i[grant_q];
        sel_wdf_end  = req_app_wdf_end_i[grant_q];
        sel_wdf_data = grant_q ? req_app_wdf_data_i[data_width_p +: data_width_p]
                               : req_app_wdf_data_i[0 +: data_width_p];
        sel_wdf_mask = grant_q ? req_app_wdf_mask_i[mask_width_lp +: mask_width_lp]
                               : req_app_wdf_mask_i[0 +: mask_width_lp];
    end

    // Eligibility and round-robin pick; reads are held off while the ID FIFO is full.
    always_comb begin
        req_is_read[0] = (req_app_cmd_i[2:0] == APP_CMD_READ);
        req_is_read[1] = (req_app_cmd_i[5:3] == APP_CMD_READ);
        eligible       = req_app_en_i & ~(req_is_read & {2{fifo_full}});
        pick           = eligible[~last_grant_q] ? ~last_grant_q : last_grant_q;
        cmd_accept     = (state_q == S_CMD) & sel_en & app_rdy_i;
        wdf_beat       = (state_q == S_WDATA) & sel_wren & app_wdf_rdy_i;
        last_beat      = (beat_cnt_q == cnt_width_lp'(burst_len_p - 1));
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Next-state logic: grant, hold until accepted, then either log the read or stream the burst.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        fifo_push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_CMD;
                    grant_d = pick;
                end
            end
            S_CMD: begin
                if (cmd_accept) begin
                    last_grant_d = grant_q;
                    if (sel_cmd == APP_CMD_READ) begin
                        fifo_push = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        beat_cnt_d = '0;
                        state_d    = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (wdf_beat) begin
                    beat_cnt_d = beat_cnt_q + cnt_width_lp'(1);
                    if (last_beat) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: only the granted requester sees ready, and only in the matching phase.
    always_comb begin
        app_addr_o              = '0;
        app_cmd_o               = '0;
        app_en_o                = 1'b0;
        req_app_rdy_o           = '0;
        app_wdf_wren_o          = 1'b0;
        app_wdf_data_o          = '0;
        app_wdf_mask_o          = '0;
        app_wdf_end_o           = 1'b0;
        req_app_wdf_rdy_o       = '0;
        req_app_rd_data_valid_o = '0;
        req_app_rd_data_end_o   = '0;
        unique case (state_q)
            S_CMD: begin
                app_addr_o             = sel_addr;
                app_cmd_o              = sel_cmd;
                app_en_o               = sel_en;
                req_app_rdy_o[grant_q] = app_rdy_i;
            end
            S_WDATA: begin
                app_wdf_wren_o             = sel_wren;
                app_wdf_data_o             = sel_wdf_data;
                app_wdf_mask_o             = sel_wdf_mask;
                app_wdf_end_o              = sel_wdf_end;
                req_app_wdf_rdy_o[grant_q] = app_wdf_rdy_i;
            end
            default: ;
        endcase
        if (!fifo_empty) begin
            req_app_rd_data_valid_o[fifo_head] = app_rd_data_valid_i;
            req_app_rd_data_end_o[fifo_head]   = app_rd_data_valid_i & app_rd_data_end_i;
        end
        // Read data is a straight broadcast, so it is the one output that needs explicit gating in reset.
        req_app_rd_data_o = reset_i ? '0 : app_rd_data_i;
        busy_o            = (state_q != S_IDLE) | ~fifo_empty;
    end

    assign fifo_full  = (fifo_cnt_q == fill_width_lp'(rd_ids_els_p));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = fifo_mem_q[fifo_rd_ptr_q];
    assign fifo_pop   = app_rd_data_valid_i & app_rd_data_end_i & ~fifo_empty;

    // Read-ID FIFO storage and pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_mem_q    <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            fifo_mem_q    <= fifo_mem_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Read-ID FIFO update: push the granted ID on read accept, pop on the last returned beat.
    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        if (fifo_push) begin
            fifo_mem_d[fifo_wr_ptr_q] = grant_q;
            fifo_wr_ptr_d             = ptr_inc(fifo_wr_ptr_q);
        end
        if (fifo_pop) begin
            fifo_rd_ptr_d = ptr_inc(fifo_rd_ptr_q);
        end
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + fill_width_lp'(1);
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - fill_width_lp'(1);
        end
    end

    // A granted requester must keep its command up until the controller takes it.
    a_en_held: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == S_CMD) |-> sel_en);

    // The end flag must mark exactly the final beat of a burst.
    a_wdf_end: assert property (@(posedge clk_i) disable iff (reset_i)
        wdf_beat |-> (sel_wdf_end == last_beat));

    // Read data with no outstanding read has nowhere to go.
    a_rd_orphan: assert property (@(posedge clk_i) disable iff (reset_i)
        app_rd_data_valid_i |-> !fifo_empty);

    // Grant gating on a full FIFO keeps pushes from overflowing it.
    a_fifo_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        fifo_push |-> !fifo_full);

endmodule
